// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Types and constants shared across the pipeline stages of the 5-stage RISC-V
// core.
//   wb_sel_t : result-select encoding used by the writeback stage
//   F3_*     : funct3 encodings of the load instructions
// -----------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage : core_pkg

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
// Bundles the MEM->WB instruction fields and the register-file write port.
//   master : MEM stage / register file side (drives the *_i fields)
//   slave  : writeback stage (drives the register-file write port)
// Fields:
//   mem_valid_i, rd_addr_i, reg_wr_en_i, wb_sel_i, alu_result_i,
//   pc_plus4_i, load_funct3_i       : instruction leaving MEM
//   wr_addr_o, wr_data_o, wr_en_o   : register-file write / forward source
// -----------------------------------------------------------------------------
interface wb_stage_if #(
  parameter int DATA_WIDTH         = 32,
  parameter int REG_MEM_ADDR_WIDTH = 5
);

  logic                          mem_valid_i;
  logic [REG_MEM_ADDR_WIDTH-1:0] rd_addr_i;
  logic                          reg_wr_en_i;
  logic [1:0]                    wb_sel_i;
  logic [DATA_WIDTH-1:0]         alu_result_i;
  logic [DATA_WIDTH-1:0]         pc_plus4_i;
  logic [2:0]                    load_funct3_i;

  logic [REG_MEM_ADDR_WIDTH-1:0] wr_addr_o;
  logic [DATA_WIDTH-1:0]         wr_data_o;
  logic                          wr_en_o;

  modport master (
    output mem_valid_i, rd_addr_i, reg_wr_en_i, wb_sel_i,
           alu_result_i, pc_plus4_i, load_funct3_i,
    input  wr_addr_o, wr_data_o, wr_en_o
  );

  modport slave (
    input  mem_valid_i, rd_addr_i, reg_wr_en_i, wb_sel_i,
           alu_result_i, pc_plus4_i, load_funct3_i,
    output wr_addr_o, wr_data_o, wr_en_o
  );

endinterface : wb_stage_if

// File: rtl/wb_stage_load_extender.sv
// -----------------------------------------------------------------------------
// load_extender
// Combinational alignment and sign/zero extension of a raw memory word.
//   funct3_i   : load type (F3_LB/LH/LW/LBU/LHU, others yield 0)
//   offset_i   : byte offset of the access within the word
//   raw_i      : raw memory word
//   data_o     : aligned, extended load data
//   misalign_o : LH/LHU on an odd offset, or LW on a non-zero offset
// -----------------------------------------------------------------------------
module load_extender
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            offset_i,
  input  logic [DATA_WIDTH-1:0] raw_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection: a byte is picked by the full offset, a half by offset[1].
  assign byte_sel = raw_i[{offset_i, 3'b000} +: 8];
  assign half_sel = raw_i[{offset_i[1], 4'b0000} +: 16];

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    data_o     = '0;
    misalign_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_LH: begin
        data_o     = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
        misalign_o = offset_i[0];
      end
      F3_LHU: begin
        data_o     = {{(DATA_WIDTH-16){1'b0}}, half_sel};
        misalign_o = offset_i[0];
      end
      F3_LW: begin
        data_o     = raw_i;
        misalign_o = (offset_i != 2'b00);
      end
      default: ;  // reserved load encodings produce 0 without a fault
    endcase
  end

endmodule : load_extender

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback stage: MEM/WB pipeline register, load alignment, result select,
// register-file write port (also the WB forwarding source) and the
// retired-instruction counter.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall_i           : hold the MEM/WB register
//   flush_i           : kill the instruction entering WB (beats stall_i)
//   load_data_i       : raw memory word, valid during the WB cycle
//   bus               : MEM->WB fields in, register-file write port out
//   wb_valid_o        : valid instruction in WB
//   load_misalign_o   : misaligned load in WB (its write is suppressed)
//   instret_o         : retired instruction count
// -----------------------------------------------------------------------------
module wb_stage
  import core_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int REG_MEM_ADDR_WIDTH = 5,
  parameter int INSTRET_WIDTH      = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic [DATA_WIDTH-1:0]    load_data_i,
  wb_stage_if.slave                bus,
  output logic                     wb_valid_o,
  output logic                     load_misalign_o,
  output logic [INSTRET_WIDTH-1:0] instret_o
);

  // MEM/WB pipeline register
  logic                          valid_q,      valid_d;
  logic [REG_MEM_ADDR_WIDTH-1:0] rd_q,         rd_d;
  logic                          reg_wr_en_q,  reg_wr_en_d;
  logic [1:0]                    wb_sel_q,     wb_sel_d;
  logic [DATA_WIDTH-1:0]         alu_result_q, alu_result_d;
  logic [DATA_WIDTH-1:0]         pc_plus4_q,   pc_plus4_d;
  logic [2:0]                    funct3_q,     funct3_d;
  logic [INSTRET_WIDTH-1:0]      instret_q,    instret_d;

  logic [DATA_WIDTH-1:0] load_ext;
  logic                  misalign_raw;
  logic                  misalign;
  logic [DATA_WIDTH-1:0] result;

  // Flush only clears valid; the payload is don't-care once valid is low.
  always_comb begin
    valid_d      = valid_q;
    rd_d         = rd_q;
    reg_wr_en_d  = reg_wr_en_q;
    wb_sel_d     = wb_sel_q;
    alu_result_d = alu_result_q;
    pc_plus4_d   = pc_plus4_q;
    funct3_d     = funct3_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      valid_d      = bus.mem_valid_i;
      rd_d         = bus.rd_addr_i;
      reg_wr_en_d  = bus.reg_wr_en_i;
      wb_sel_d     = bus.wb_sel_i;
      alu_result_d = bus.alu_result_i;
      pc_plus4_d   = bus.pc_plus4_i;
      funct3_d     = bus.load_funct3_i;
    end
  end

  // An instruction retires when it leaves WB undisturbed; a stalled
  // instruction re-issues its write but is only counted once.
  always_comb begin
    instret_d = instret_q;
    if (valid_q && !stall_i && !flush_i) begin
      instret_d = instret_q + INSTRET_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      rd_q         <= '0;
      reg_wr_en_q  <= 1'b0;
      wb_sel_q     <= WB_ALU;
      alu_result_q <= '0;
      pc_plus4_q   <= '0;
      funct3_q     <= '0;
      instret_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      rd_q         <= rd_d;
      reg_wr_en_q  <= reg_wr_en_d;
      wb_sel_q     <= wb_sel_d;
      alu_result_q <= alu_result_d;
      pc_plus4_q   <= pc_plus4_d;
      funct3_q     <= funct3_d;
      instret_q    <= instret_d;
    end
  end

  load_extender #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extender (
    .funct3_i   (funct3_q),
    .offset_i   (alu_result_q[1:0]),
    .raw_i      (load_data_i),
    .data_o     (load_ext),
    .misalign_o (misalign_raw)
  );

  // The extender flags any misaligned funct3/offset pair; it only matters for
  // a live load.
  assign misalign = valid_q && (wb_sel_q == WB_MEM) && misalign_raw;

  always_comb begin
    result = '0;
    case (wb_sel_q)
      WB_ALU:  result = alu_result_q;
      WB_MEM:  result = load_ext;
      WB_PC4:  result = pc_plus4_q;
      default: result = '0;
    endcase
  end

  assign bus.wr_addr_o = rd_q;
  assign bus.wr_data_o = result;
  assign bus.wr_en_o   = valid_q && reg_wr_en_q && (rd_q != '0) && !misalign;

  assign wb_valid_o      = valid_q;
  assign load_misalign_o = misalign;
  assign instret_o       = instret_q;

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Directed self-checking bench for wb_stage. Inputs change and outputs are
// sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_stage;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] load_data;
  logic        wb_valid;
  logic        misalign;
  logic [63:0] instret;

  int total;
  int bad;

  wb_stage_if #(.DATA_WIDTH(32), .REG_MEM_ADDR_WIDTH(5)) bus ();

  wb_stage #(
    .DATA_WIDTH         (32),
    .REG_MEM_ADDR_WIDTH (5),
    .INSTRET_WIDTH      (64)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall),
    .flush_i         (flush),
    .load_data_i     (load_data),
    .bus             (bus.slave),
    .wb_valid_o      (wb_valid),
    .load_misalign_o (misalign),
    .instret_o       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [2:0] f3);
    bus.mem_valid_i   = v;
    bus.rd_addr_i     = rd;
    bus.reg_wr_en_i   = we;
    bus.wb_sel_i      = sel;
    bus.alu_result_i  = alu;
    bus.pc_plus4_i    = pc4;
    bus.load_funct3_i = f3;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 3'b000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; load_data = 32'h0;
    idle();
    #12;
    total++; if (bus.wr_en_o !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0h exp=0", bus.wr_en_o); end
    total++; if (bus.wr_addr_o !== 5'd0) begin bad++; $display("FAIL reset_wr_addr got=%0h exp=0", bus.wr_addr_o); end
    total++; if (bus.wr_data_o !== 32'h0) begin bad++; $display("FAIL reset_wr_data got=%0h exp=0", bus.wr_data_o); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0h exp=0", wb_valid); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%0h exp=0", misalign); end
    total++; if (instret !== 64'd0) begin bad++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    drive(1'b1, 5'd5, 1'b1, WB_ALU, 32'h1234_5678, 32'h0, 3'b000);
    step();
    idle();
    total++; if (bus.wr_en_o !== 1'b1) begin bad++; $display("FAIL alu_wr_en got=%0h exp=1", bus.wr_en_o); end
    total++; if (bus.wr_addr_o !== 5'd5) begin bad++; $display("FAIL alu_wr_addr got=%0d exp=5", bus.wr_addr_o); end
    total++; if (bus.wr_data_o !== 32'h1234_5678) begin bad++; $display("FAIL alu_wr_data got=%0h exp=12345678", bus.wr_data_o); end
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu_wb_valid got=%0h exp=1", wb_valid); end
    total++; if (instret !== 64'd0) begin bad++; $display("FAIL alu_instret_pre got=%0d exp=0", instret); end
    step();
    total++; if (instret !== 64'd1) begin bad++; $display("FAIL alu_instret_post got=%0d exp=1", instret); end
    total++; if (bus.wr_en_o !== 1'b0) begin bad++; $display("FAIL alu_wr_en_after got=%0h exp=0", bus.wr_en_o); end
  endtask

  task automatic test_load();
    logic [2:0]  f3  [9];
    logic [1:0]  off [9];
    logic [31:0] exp [9];
    logic [63:0] base;
    f3  = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW, F3_LB, F3_LBU, 3'b011, 3'b110};
    off = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_FF7F,
            32'h80FF_FF7F, 32'hFFFF_FFFF, 32'h0000_007F, 32'h0, 32'h0};
    base = instret;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 5'd3, 1'b1, WB_MEM, {30'h400, off[i]}, 32'h0, f3[i]);
      step();
      load_data = 32'h80FF_FF7F;
      #1;
      total++; if (bus.wr_data_o !== exp[i]) begin bad++; $display("FAIL load_data[%0d] got=%0h exp=%0h", i, bus.wr_data_o, exp[i]); end
      total++; if (misalign !== 1'b0 || bus.wr_en_o !== 1'b1) begin bad++; $display("FAIL load_flags[%0d] got mis=%0h wen=%0h exp mis=0 wen=1", i, misalign, bus.wr_en_o); end
    end
    idle();
    step();
    total++; if (instret !== base + 64'd9) begin bad++; $display("FAIL load_instret got=%0d exp=%0d", instret, base + 64'd9); end
  endtask

  task automatic test_misalign();
    logic [2:0]  f3  [5];
    logic [1:0]  off [5];
    logic [1:0]  sel [5];
    logic        mis [5];
    logic [63:0] base;
    f3  = '{F3_LW, F3_LH, F3_LHU, F3_LH, F3_LW};
    off = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
    sel = '{WB_MEM, WB_MEM, WB_MEM, WB_MEM, WB_ALU};
    mis = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    load_data = 32'h80FF_FF7F;
    base = instret;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd7, 1'b1, sel[i], {30'h400, off[i]}, 32'h0, f3[i]);
      step();
      total++; if (misalign !== mis[i]) begin bad++; $display("FAIL mis_flag[%0d] got=%0h exp=%0h", i, misalign, mis[i]); end
      total++; if (bus.wr_en_o !== !mis[i]) begin bad++; $display("FAIL mis_wr_en[%0d] got=%0h exp=%0h", i, bus.wr_en_o, !mis[i]); end
    end
    total++; if (bus.wr_data_o !== 32'h0000_1002) begin bad++; $display("FAIL mis_alu_data got=%0h exp=1002", bus.wr_data_o); end
    idle();
    step();
    total++; if (instret !== base + 64'd5) begin bad++; $display("FAIL mis_instret got=%0d exp=%0d", instret, base + 64'd5); end
  endtask

  task automatic test_jal();
    drive(1'b1, 5'd0, 1'b1, WB_PC4, 32'h55, 32'h100, 3'b000);
    step();
    total++; if (bus.wr_en_o !== 1'b0) begin bad++; $display("FAIL jal_x0_wr_en got=%0h exp=0", bus.wr_en_o); end
    total++; if (bus.wr_data_o !== 32'h100) begin bad++; $display("FAIL jal_x0_data got=%0h exp=100", bus.wr_data_o); end
    drive(1'b1, 5'd1, 1'b1, WB_PC4, 32'h55, 32'h100, 3'b000);
    step();
    total++; if (bus.wr_en_o !== 1'b1) begin bad++; $display("FAIL jal_x1_wr_en got=%0h exp=1", bus.wr_en_o); end
    total++; if (bus.wr_data_o !== 32'h100 || bus.wr_addr_o !== 5'd1) begin bad++; $display("FAIL jal_x1_data got=%0h/%0d exp=100/1", bus.wr_data_o, bus.wr_addr_o); end
    drive(1'b1, 5'd2, 1'b1, 2'b11, 32'h55, 32'h100, 3'b000);
    step();
    total++; if (bus.wr_data_o !== 32'h0) begin bad++; $display("FAIL sel11_data got=%0h exp=0", bus.wr_data_o); end
    idle();
    step();
  endtask

  task automatic test_stall();
    logic [63:0] base;
    drive(1'b1, 5'd9, 1'b1, WB_ALU, 32'hCAFE_0001, 32'h0, 3'b000);
    step();
    stall = 1'b1;
    drive(1'b1, 5'd10, 1'b1, WB_ALU, 32'h0BAD_0002, 32'h0, 3'b000);
    base = instret;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.wr_en_o !== 1'b1 || bus.wr_addr_o !== 5'd9 || bus.wr_data_o !== 32'hCAFE_0001) begin
        bad++; $display("FAIL stall_hold[%0d] got wen=%0h rd=%0d d=%0h exp wen=1 rd=9 d=cafe0001", i, bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o); end
      total++; if (instret !== base) begin bad++; $display("FAIL stall_instret[%0d] got=%0d exp=%0d", i, instret, base); end
      step();
    end
    stall = 1'b0;
    step();
    total++; if (instret !== base + 64'd1) begin bad++; $display("FAIL stall_release_instret got=%0d exp=%0d", instret, base + 64'd1); end
    total++; if (bus.wr_addr_o !== 5'd10 || bus.wr_data_o !== 32'h0BAD_0002) begin bad++; $display("FAIL stall_next got rd=%0d d=%0h exp rd=10 d=bad0002", bus.wr_addr_o, bus.wr_data_o); end
    idle();
    stall = 1'b1;
    flush = 1'b1;
    step();
    total++; if (wb_valid !== 1'b0 || bus.wr_en_o !== 1'b0) begin bad++; $display("FAIL stall_flush got v=%0h wen=%0h exp v=0 wen=0", wb_valid, bus.wr_en_o); end
    total++; if (instret !== base + 64'd1) begin bad++; $display("FAIL stall_flush_instret got=%0d exp=%0d", instret, base + 64'd1); end
    stall = 1'b0;
    flush = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd4, 1'b1, WB_ALU, 32'h44, 32'h0, 3'b000);
    step();
    total++; if (bus.wr_en_o !== 1'b1) begin bad++; $display("FAIL areset_pre_wr_en got=%0h exp=1", bus.wr_en_o); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.wr_en_o !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL areset_wr_en got wen=%0h v=%0h exp 0/0", bus.wr_en_o, wb_valid); end
    total++; if (instret !== 64'd0) begin bad++; $display("FAIL areset_instret got=%0d exp=0", instret); end
    total++; if (bus.wr_addr_o !== 5'd0 || bus.wr_data_o !== 32'h0) begin bad++; $display("FAIL areset_port got rd=%0d d=%0h exp 0/0", bus.wr_addr_o, bus.wr_data_o); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++; if (bus.wr_en_o !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL areset_post_wr_en got wen=%0h v=%0h exp 0/0", bus.wr_en_o, wb_valid); end
    total++; if (instret !== 64'd0) begin bad++; $display("FAIL areset_post_instret got=%0d exp=0", instret); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alu();
    test_load();
    test_misalign();
    test_jal();
    test_stall();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_stage
